// File: rtl/bus_pkg.sv
// Shared definitions for the bus request controller: FSM encoding, status codes, CRC polynomial.
// Imported by bus_request_ctrl and crc8_byte.
package bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_TX_FREE = 3'd1,
        S_START_TX     = 3'd2,
        S_CLEAR_TX     = 3'd3,
        S_WAIT_TX_DONE = 3'd4,
        S_RX_DATA      = 3'd5,
        S_RX_CRC       = 3'd6,
        S_CHECK        = 3'd7
    } state_t;

    localparam logic [2:0] ST_WAIT_TX  = 3'd0;
    localparam logic [2:0] ST_WAIT_RX  = 3'd1;
    localparam logic [2:0] ST_OK       = 3'd2;
    localparam logic [2:0] ST_CRC_ERR  = 3'd3;
    localparam logic [2:0] ST_TIMEOUT  = 3'd4;

    localparam logic [7:0] CRC8_POLY   = 8'h07;

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 byte step (MSB first, no reflection): crc_out = CRC(crc_in, byte_in).
// Purely combinational, zero latency.
module crc8_byte
    import bus_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[7]) begin
                w_acc = {w_acc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_acc = {w_acc[6:0], 1'b0};
            end
        end
        crc_out = w_acc;
    end

endmodule

// File: rtl/bus_request_ctrl.sv
// Bus request controller: sends a command byte over UART TX, collects payload + CRC-8 from UART RX, reports status.
// Define BUS_CTRL_TIMEOUT_EN to compile in the receive timeout with automatic retransmission.
module bus_request_ctrl
    import bus_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES    = 2
)
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [7:0]                 command,
    input  logic [7:0]                 data_rx,
    input  logic                       done_rx,
    input  logic                       active_tx,
    input  logic                       done_tx,
    output logic [7:0]                 tx_data,
    output logic                       enable_tx,
    output logic [8*PAYLOAD_BYTES-1:0] data,
    output logic [7:0]                 crc,
    output logic [2:0]                 status,
    output logic [2:0]                 retries,
    output logic                       done
);

    localparam int DW    = 8 * PAYLOAD_BYTES;
    localparam int CNT_W = 4;

    generate
        if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 16 || MAX_RETRIES < 0 || MAX_RETRIES > 7 ||
            TIMEOUT_CYCLES < 2) begin : g_bad_params
            $error("bus_request_ctrl: parameter out of range");
        end
    endgenerate

    state_t             r_state,     w_state_nxt;
    logic [7:0]         r_tx_data,   w_tx_data_nxt;
    logic               r_enable_tx, w_enable_tx_nxt;
    logic [DW-1:0]      r_data,      w_data_nxt;
    logic [7:0]         r_crc,       w_crc_nxt;
    logic [2:0]         r_status,    w_status_nxt;
    logic [2:0]         r_retries,   w_retries_nxt;
    logic               r_done,      w_done_nxt;
    logic [CNT_W-1:0]   r_count,     w_count_nxt;
    logic [7:0]         r_crc_run,   w_crc_run_nxt;
    logic [7:0]         w_crc_step;

`ifdef BUS_CTRL_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0]   r_timer,     w_timer_nxt;
`endif

    crc8_byte u_crc8 (
        .crc_in  (r_crc_run),
        .byte_in (data_rx),
        .crc_out (w_crc_step)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_tx_data_nxt   = r_tx_data;
        w_enable_tx_nxt = 1'b0;
        w_data_nxt      = r_data;
        w_crc_nxt       = r_crc;
        w_status_nxt    = r_status;
        w_retries_nxt   = r_retries;
        w_done_nxt      = 1'b0;
        w_count_nxt     = r_count;
        w_crc_run_nxt   = r_crc_run;
`ifdef BUS_CTRL_TIMEOUT_EN
        w_timer_nxt     = r_timer;
`endif

        // A request pulse restarts from any state; a coincident received byte is dropped.
        if (enable) begin
            w_tx_data_nxt = command;
            w_retries_nxt = 3'd0;
            w_status_nxt  = ST_WAIT_TX;
            w_state_nxt   = S_WAIT_TX_FREE;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_WAIT_TX_FREE: begin
                    if (!(active_tx || done_tx)) begin
                        w_state_nxt = S_START_TX;
                    end
                end
                S_START_TX: begin
                    w_enable_tx_nxt = 1'b1;
                    w_state_nxt     = S_CLEAR_TX;
                end
                S_CLEAR_TX: begin
                    w_state_nxt = S_WAIT_TX_DONE;
                end
                S_WAIT_TX_DONE: begin
                    if (done_tx) begin
                        w_status_nxt  = ST_WAIT_RX;
                        w_count_nxt   = '0;
                        w_crc_run_nxt = 8'h00;
`ifdef BUS_CTRL_TIMEOUT_EN
                        w_timer_nxt   = '0;
`endif
                        w_state_nxt   = S_RX_DATA;
                    end
                end
                S_RX_DATA: begin
                    if (done_rx) begin
                        w_data_nxt[DW-8-8*int'(r_count) +: 8] = data_rx;
                        w_crc_run_nxt = w_crc_step;
                        if (r_count == CNT_W'(PAYLOAD_BYTES - 1)) begin
                            w_state_nxt = S_RX_CRC;
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                end
                S_RX_CRC: begin
                    if (done_rx) begin
                        w_crc_nxt   = data_rx;
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    w_status_nxt = (r_crc_run == r_crc) ? ST_OK : ST_CRC_ERR;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase

`ifdef BUS_CTRL_TIMEOUT_EN
            // Timer restarts on every received byte; a byte on the expiry cycle beats the timeout.
            if (r_state == S_RX_DATA || r_state == S_RX_CRC) begin
                if (done_rx) begin
                    w_timer_nxt = '0;
                end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timer_nxt = '0;
                    if (r_retries < 3'(MAX_RETRIES)) begin
                        w_retries_nxt = r_retries + 3'd1;
                        w_status_nxt  = ST_WAIT_TX;
                        w_state_nxt   = S_WAIT_TX_FREE;
                    end else begin
                        w_status_nxt  = ST_TIMEOUT;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tx_data   <= 8'h00;
            r_enable_tx <= 1'b0;
            r_data      <= '0;
            r_crc       <= 8'h00;
            r_status    <= ST_OK;
            r_retries   <= 3'd0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_crc_run   <= 8'h00;
`ifdef BUS_CTRL_TIMEOUT_EN
            r_timer     <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_enable_tx <= w_enable_tx_nxt;
            r_data      <= w_data_nxt;
            r_crc       <= w_crc_nxt;
            r_status    <= w_status_nxt;
            r_retries   <= w_retries_nxt;
            r_done      <= w_done_nxt;
            r_count     <= w_count_nxt;
            r_crc_run   <= w_crc_run_nxt;
`ifdef BUS_CTRL_TIMEOUT_EN
            r_timer     <= w_timer_nxt;
`endif
        end
    end

    assign tx_data   = r_tx_data;
    assign enable_tx = r_enable_tx;
    assign data      = r_data;
    assign crc       = r_crc;
    assign status    = r_status;
    assign retries   = r_retries;
    assign done      = r_done;

endmodule

// File: tb/tb_bus_request_ctrl.sv
// Bench for bus_request_ctrl: transaction-level expectations checked against the DUT every cycle.
// Timeout scenarios are exercised only when BUS_CTRL_TIMEOUT_EN is defined.
module tb_bus_request_ctrl;

    localparam int PB = 2;
    localparam int TC = 20;
    localparam int MR = 2;

    logic            clock = 1'b0;
    logic            reset, enable, done_rx, active_tx, done_tx;
    logic [7:0]      command, data_rx;
    logic [7:0]      tx_data;
    logic            enable_tx;
    logic [8*PB-1:0] data;
    logic [7:0]      crc;
    logic [2:0]      status;
    logic [2:0]      retries;
    logic            done;

    always #5 clock = ~clock;

    bus_request_ctrl #(
        .PAYLOAD_BYTES  (PB),
        .TIMEOUT_CYCLES (TC),
        .MAX_RETRIES    (MR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .command   (command),
        .data_rx   (data_rx),
        .done_rx   (done_rx),
        .active_tx (active_tx),
        .done_tx   (done_tx),
        .tx_data   (tx_data),
        .enable_tx (enable_tx),
        .data      (data),
        .crc       (crc),
        .status    (status),
        .retries   (retries),
        .done      (done)
    );

    // Expected outputs, updated by the stimulus tasks right after the edge they describe.
    logic [7:0]      e_tx_data;
    logic            e_enable_tx;
    logic [8*PB-1:0] e_data;
    logic [7:0]      e_crc;
    logic [2:0]      e_status;
    logic [2:0]      e_retries;
    logic            e_done;
    logic [7:0]      rx_q[$];
    bit              chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("tx_data",   32'(tx_data),   32'(e_tx_data));
            check("enable_tx", 32'(enable_tx), 32'(e_enable_tx));
            check("data",      32'(data),      32'(e_data));
            check("crc",       32'(crc),       32'(e_crc));
            check("status",    32'(status),    32'(e_status));
            check("retries",   32'(retries),   32'(e_retries));
            check("done",      32'(done),      32'(e_done));
        end
    end

    function automatic logic [7:0] crc8_of(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        foreach (q[i]) begin
            c = c ^ q[i];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? (8'((c << 1)) ^ 8'h07) : 8'((c << 1));
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        command = 8'hFF;
        tick();
        e_tx_data = 8'h00; e_enable_tx = 1'b0; e_data = '0; e_crc = 8'h00;
        e_status = 3'd2; e_retries = 3'd0; e_done = 1'b0;
        rx_q.delete();
        chk_en = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // FSM waits for a free transmitter; enable_tx appears two edges after it first sees one.
    task automatic tx_phase();
        int n;
        tick();
        tick();
        e_enable_tx = 1'b1;
        active_tx = 1'b1;
        tick();
        e_enable_tx = 1'b0;
        n = $urandom_range(0, 4);
        repeat (n) begin
            if ($urandom_range(0, 3) == 0) begin
                done_rx = 1'b1;
                data_rx = 8'($urandom);
            end
            tick();
            done_rx = 1'b0;
        end
        done_tx   = 1'b1;
        active_tx = 1'b0;
        tick();
        done_tx  = 1'b0;
        e_status = 3'd1;
        rx_q.delete();
    endtask

    task automatic request(input logic [7:0] cmd, input int busy, input bit with_rx);
        enable    = 1'b1;
        command   = cmd;
        active_tx = (busy > 0);
        if (with_rx) begin
            done_rx = 1'b1;
            data_rx = 8'($urandom);
        end
        tick();
        enable  = 1'b0;
        done_rx = 1'b0;
        e_tx_data = cmd; e_status = 3'd0; e_retries = 3'd0; e_done = 1'b0; e_enable_tx = 1'b0;
        repeat (busy) tick();
        active_tx = 1'b0;
        tx_phase();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            if ($urandom_range(0, 4) == 0) done_tx = 1'b1;
            tick();
            done_tx = 1'b0;
        end
        data_rx = b;
        done_rx = 1'b1;
        tick();
        done_rx = 1'b0;
        if (rx_q.size() < PB) begin
            e_data[8*(PB-1-rx_q.size()) +: 8] = b;
            rx_q.push_back(b);
        end else begin
            e_crc = b;
            tick();
            e_status = (crc8_of(rx_q) == b) ? 3'd2 : 3'd3;
            e_done   = 1'b1;
            tick();
            e_done   = 1'b0;
        end
    endtask

`ifdef BUS_CTRL_TIMEOUT_EN
    task automatic silent();
        for (int r = 0; r <= MR; r++) begin
            repeat (TC - 1) tick();
            tick();
            if (r < MR) begin
                e_retries = 3'(r + 1);
                e_status  = 3'd0;
                tx_phase();
            end else begin
                e_status = 3'd4;
                e_done   = 1'b1;
                tick();
                e_done   = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        logic [7:0] pin_q[$];
        logic [7:0] pl[$];
        logic [7:0] c;
        int k;

        reset = 1'b1; enable = 1'b0; command = 8'h00; data_rx = 8'h00;
        done_rx = 1'b0; active_tx = 1'b0; done_tx = 1'b0;
        tick();
        do_reset();

        pin_q = '{8'h12, 8'h34};
        check("model_crc_1234", 32'(crc8_of(pin_q)), 32'hF1);

        request(8'hA5, 0, 1'b0);
        send_byte(8'h12, 1); send_byte(8'h34, 0); send_byte(8'hF1, 2);
        check("ok_data", 32'(data), 32'h1234);
        check("ok_status", 32'(status), 32'd2);
        check("ok_tx_data", 32'(tx_data), 32'hA5);

        request(8'hA5, 0, 1'b0);
        send_byte(8'h12, 0); send_byte(8'h34, 3); send_byte(8'hF0, 0);
        check("crcerr_status", 32'(status), 32'd3);
        check("crcerr_data", 32'(data), 32'h1234);

        request(8'hA5, 10, 1'b0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hF1, 0);

        request(8'h11, 0, 1'b0);
        send_byte(8'hAA, 1);
        request(8'h22, 0, 1'b1);
        check("abort_retries", 32'(retries), 32'd0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hF1, 0);
        check("abort_data", 32'(data), 32'h1234);
        check("abort_status", 32'(status), 32'd2);

`ifdef BUS_CTRL_TIMEOUT_EN
        request(8'h5C, 0, 1'b0);
        silent();
        check("to_retries", 32'(retries), 32'd2);
        check("to_status", 32'(status), 32'd4);

        request(8'h3E, 0, 1'b0);
        send_byte(8'h5A, TC - 1);
        check("expiry_retries", 32'(retries), 32'd0);
        check("expiry_status", 32'(status), 32'd1);
        pin_q = '{8'h5A, 8'h6B};
        send_byte(8'h6B, 2);
        send_byte(crc8_of(pin_q), 0);
        check("expiry_done_status", 32'(status), 32'd2);
`else
        request(8'h3E, 0, 1'b0);
        send_byte(8'h5A, 3 * TC);
        check("nowait_status", 32'(status), 32'd1);
        check("nowait_retries", 32'(retries), 32'd0);
        send_byte(8'h6B, 0);
        pin_q = '{8'h5A, 8'h6B};
        send_byte(crc8_of(pin_q), 0);
`endif

        for (int t = 0; t < 40; t++) begin
            request(8'($urandom), $urandom_range(0, 4), 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, PB);
                for (int i = 0; i < k; i++) send_byte(8'($urandom), $urandom_range(0, 3));
                request(8'($urandom), $urandom_range(0, 4), (k > 0) && ($urandom_range(0, 1) == 1));
            end
            pl.delete();
            for (int i = 0; i < PB; i++) pl.push_back(8'($urandom));
            foreach (pl[i]) send_byte(pl[i], $urandom_range(0, 5));
            c = crc8_of(pl);
            if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
            send_byte(c, $urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) tick();
        end

        request(8'h77, 0, 1'b0);
        send_byte(8'h99, 0);
        do_reset();
        check("reset_data", 32'(data), 32'h0);
        check("reset_status", 32'(status), 32'd2);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
